// File: rtl/quadrature_decoder.sv
// Quadrature decoder: turns debounced A/B phases into a signed position count,
// a per-count step pulse, a direction flag and a sticky illegal-transition flag.
module quadrature_decoder #(
  parameter int CNT_WIDTH = 8,
  parameter bit WRAP      = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        clear,
  input  logic [1:0]                  res_sel,
  output logic signed [CNT_WIDTH-1:0] count,
  output logic                        step,
  output logic                        dir,
  output logic                        err
);
  typedef enum logic {UNPRIMED, TRACK} state_t;

  localparam logic signed [CNT_WIDTH-1:0] CNT_MAX  = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic signed [CNT_WIDTH-1:0] CNT_MIN  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic signed [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // Successor of a phase pair along the forward (count-up) Gray sequence.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  state_t                        state_q, state_d;
  logic [1:0]                    prev_ab_q, prev_ab_d;
  logic signed [CNT_WIDTH-1:0]   count_q, count_d;
  logic                          step_q, step_d;
  logic                          dir_q, dir_d;
  logic                          err_q, err_d;

  logic [1:0] ab, delta;
  logic       legal, illegal, is_up, qual;

  assign ab      = {enc_a, enc_b};
  assign delta   = ab ^ prev_ab_q;
  assign legal   = ^delta;
  assign illegal = &delta;
  assign is_up   = (fwd_next(prev_ab_q) == ab);

  // Resolution filter keys off the post-transition pair.
  always_comb begin
    case (res_sel)
      2'd0:    qual = (ab == 2'b00);
      2'd1:    qual = (ab[1] == ab[0]);
      default: qual = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    prev_ab_d = ab;
    count_d   = count_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    err_d     = err_q;
    case (state_q)
      UNPRIMED: state_d = TRACK;
      TRACK: begin
        // A transition coinciding with clear is dropped entirely.
        if (!clear) begin
          if (illegal) begin
            err_d = 1'b1;
          end else if (legal && qual) begin
            dir_d = is_up;
            if (is_up) begin
              if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
                step_d  = 1'b1;
              end else if (WRAP) begin
                count_d = CNT_MIN;
                step_d  = 1'b1;
              end
            end else begin
              if (count_q != CNT_MIN) begin
                count_d = count_q - CNT_ONE;
                step_d  = 1'b1;
              end else if (WRAP) begin
                count_d = CNT_MAX;
                step_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = UNPRIMED;
    endcase
    if (clear) begin
      count_d = CNT_ZERO;
      err_d   = 1'b0;
    end
  end

  // Being in TRACK is what marks prev_ab_q as primed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNPRIMED;
      prev_ab_q <= 2'b00;
      count_q   <= CNT_ZERO;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_ab_q <= prev_ab_d;
      count_q   <= count_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench: drives a wrapping and a saturating decoder in parallel from
// directed vectors; a monitor pops per-cycle expectations and compares.
module tb_quadrature_decoder;
  logic       clk = 1'b0;
  logic       reset, enc_a, enc_b, clear;
  logic [1:0] res_sel;
  logic signed [7:0] count_w, count_s;
  logic       step_w, step_s, dir_w, dir_s, err_w, err_s;

  typedef struct {
    logic [7:0] cw;
    logic       sw;
    logic [7:0] cs;
    logic       ss;
    logic       dir;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  quadrature_decoder #(.CNT_WIDTH(8), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .res_sel(res_sel), .count(count_w), .step(step_w), .dir(dir_w), .err(err_w));

  quadrature_decoder #(.CNT_WIDTH(8), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .res_sel(res_sel), .count(count_s), .step(step_s), .dir(dir_s), .err(err_s));

  function automatic logic [1:0] up_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] down_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // One vector per cycle: inputs applied on the falling edge, expectation
  // describes the outputs after the following rising edge.
  task automatic vec(input logic [1:0] ab, input logic clr, input logic [1:0] rs,
                     input logic rst, input logic [7:0] cw, input logic sw,
                     input logic [7:0] cs, input logic ss, input logic d, input logic e);
    exp_t x;
    @(negedge clk);
    {enc_a, enc_b} = ab;
    clear   = clr;
    res_sel = rs;
    reset   = rst;
    x.cw = cw; x.sw = sw; x.cs = cs; x.ss = ss; x.dir = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic v(input logic [1:0] ab, input logic clr, input logic [1:0] rs,
                   input logic rst, input logic [7:0] c, input logic s,
                   input logic d, input logic e);
    vec(ab, clr, rs, rst, c, s, c, s, d, e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, vectors, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      chk("count_wrap", count_w, x.cw);
      chk("step_wrap",  {7'd0, step_w}, {7'd0, x.sw});
      chk("count_sat",  count_s, x.cs);
      chk("step_sat",   {7'd0, step_s}, {7'd0, x.ss});
      chk("dir_wrap",   {7'd0, dir_w}, {7'd0, x.dir});
      chk("dir_sat",    {7'd0, dir_s}, {7'd0, x.dir});
      chk("err_wrap",   {7'd0, err_w}, {7'd0, x.err});
      chk("err_sat",    {7'd0, err_s}, {7'd0, x.err});
    end
  end

  initial begin
    logic [1:0] ab;
    reset = 1'b1; clear = 1'b0; res_sel = 2'd2; {enc_a, enc_b} = 2'b00;

    // Reset, then priming cycle.
    v(2'b00, 0, 2, 1, 8'd0, 0, 0, 0);
    v(2'b00, 0, 2, 1, 8'd0, 0, 0, 0);
    v(2'b00, 0, 2, 0, 8'd0, 0, 0, 0);

    // x4 forward cycle, one change every 3 cycles.
    v(2'b01, 0, 2, 0, 8'd1, 1, 1, 0); v(2'b01, 0, 2, 0, 8'd1, 0, 1, 0); v(2'b01, 0, 2, 0, 8'd1, 0, 1, 0);
    v(2'b11, 0, 2, 0, 8'd2, 1, 1, 0); v(2'b11, 0, 2, 0, 8'd2, 0, 1, 0); v(2'b11, 0, 2, 0, 8'd2, 0, 1, 0);
    v(2'b10, 0, 2, 0, 8'd3, 1, 1, 0); v(2'b10, 0, 2, 0, 8'd3, 0, 1, 0); v(2'b10, 0, 2, 0, 8'd3, 0, 1, 0);
    v(2'b00, 0, 2, 0, 8'd4, 1, 1, 0); v(2'b00, 0, 2, 0, 8'd4, 0, 1, 0); v(2'b00, 0, 2, 0, 8'd4, 0, 1, 0);

    // Clear, then x1 reverse cycle: only 01->00 counts.
    v(2'b00, 1, 0, 0, 8'd0, 0, 1, 0);
    v(2'b10, 0, 0, 0, 8'd0, 0, 1, 0);
    v(2'b11, 0, 0, 0, 8'd0, 0, 1, 0);
    v(2'b01, 0, 0, 0, 8'd0, 0, 1, 0);
    v(2'b00, 0, 0, 0, 8'hFF, 1, 0, 0);

    // x2 forward cycle: counts on entry to 11 and 00.
    v(2'b01, 0, 1, 0, 8'hFF, 0, 0, 0);
    v(2'b11, 0, 1, 0, 8'd0, 1, 1, 0);
    v(2'b10, 0, 1, 0, 8'd0, 0, 1, 0);
    v(2'b00, 0, 1, 0, 8'd1, 1, 1, 0);

    // Illegal jump, clear swallowing a legal step, then a counted step.
    v(2'b11, 0, 2, 0, 8'd1, 0, 1, 1);
    v(2'b10, 1, 2, 0, 8'd0, 0, 1, 0);
    v(2'b00, 0, 2, 0, 8'd1, 1, 1, 0);

    // Reach count 5 sitting at 11 (x1 ignores the last two moves).
    v(2'b01, 0, 2, 0, 8'd2, 1, 1, 0);
    v(2'b11, 0, 2, 0, 8'd3, 1, 1, 0);
    v(2'b10, 0, 2, 0, 8'd4, 1, 1, 0);
    v(2'b00, 0, 2, 0, 8'd5, 1, 1, 0);
    v(2'b01, 0, 0, 0, 8'd5, 0, 1, 0);
    v(2'b11, 0, 0, 0, 8'd5, 0, 1, 0);

    // Reset mid-run (with clear also high), prime at 11, then 11->10 counts up.
    v(2'b11, 1, 2, 1, 8'd0, 0, 0, 0);
    v(2'b11, 0, 2, 0, 8'd0, 0, 0, 0);
    v(2'b10, 0, 2, 0, 8'd1, 1, 1, 0);

    // Ramp to 127, then probe the upper limit on both instances.
    v(2'b10, 1, 2, 0, 8'd0, 0, 1, 0);
    ab = 2'b10;
    for (int i = 1; i <= 127; i++) begin
      ab = up_of(ab);
      v(ab, 0, 2, 0, 8'(i), 1, 1, 0);
    end
    ab = up_of(ab);
    vec(ab, 0, 2, 0, 8'h80, 1, 8'h7F, 0, 1, 0);
    ab = up_of(ab);
    vec(ab, 0, 2, 0, 8'h81, 1, 8'h7F, 0, 1, 0);
    ab = down_of(ab);
    vec(ab, 0, 2, 0, 8'h80, 1, 8'h7E, 1, 0, 0);
    ab = down_of(ab);
    vec(ab, 0, 2, 0, 8'h7F, 1, 8'h7D, 1, 0, 0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
